// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide unit owning the HI/LO registers.
// Holds the pipeline through stall_req while a MULT/DIV is in flight.
module muldiv_unit #(
    parameter int DATA_WIDTH  = 32,
    parameter int FUNCT_WIDTH = 6
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ex_valid,
    input  logic                   ex_stall,
    input  logic                   flush,
    input  logic [FUNCT_WIDTH-1:0] funct,
    input  logic [DATA_WIDTH-1:0]  op_a,
    input  logic [DATA_WIDTH-1:0]  op_b,
    output logic                   stall_req,
    output logic                   busy,
    output logic [DATA_WIDTH-1:0]  hi_out,
    output logic [DATA_WIDTH-1:0]  lo_out,
    output logic [DATA_WIDTH-1:0]  result
);

    localparam int CNT_W = $clog2(DATA_WIDTH);

    localparam logic [FUNCT_WIDTH-1:0] F_MFHI  = FUNCT_WIDTH'(6'h10);
    localparam logic [FUNCT_WIDTH-1:0] F_MTHI  = FUNCT_WIDTH'(6'h11);
    localparam logic [FUNCT_WIDTH-1:0] F_MFLO  = FUNCT_WIDTH'(6'h12);
    localparam logic [FUNCT_WIDTH-1:0] F_MTLO  = FUNCT_WIDTH'(6'h13);
    localparam logic [FUNCT_WIDTH-1:0] F_MULT  = FUNCT_WIDTH'(6'h18);
    localparam logic [FUNCT_WIDTH-1:0] F_MULTU = FUNCT_WIDTH'(6'h19);
    localparam logic [FUNCT_WIDTH-1:0] F_DIV   = FUNCT_WIDTH'(6'h1A);
    localparam logic [FUNCT_WIDTH-1:0] F_DIVU  = FUNCT_WIDTH'(6'h1B);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ITER,
        S_FIN
    } state_t;

    state_t                      state_q, state_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]       hi_q, hi_d;
    logic [DATA_WIDTH-1:0]       lo_q, lo_d;
    logic [2*DATA_WIDTH-1:0]     w_q, w_d;
    logic [DATA_WIDTH-1:0]       m_q, m_d;
    logic                        is_div_q, is_div_d;
    logic                        neg_lo_q, neg_lo_d;
    logic                        neg_hi_q, neg_hi_d;
    logic                        busy_q, busy_d;

    logic                        go;
    logic                        is_mul_op, is_div_op, is_signed_op;
    logic                        sign_a, sign_b;
    logic [DATA_WIDTH-1:0]       abs_a, abs_b;
    logic [DATA_WIDTH:0]         mul_sum;
    logic [2*DATA_WIDTH-1:0]     mul_next;
    logic [DATA_WIDTH:0]         div_rs;
    logic                        div_ge;
    logic [DATA_WIDTH-1:0]       div_diff, div_rem;
    logic [2*DATA_WIDTH-1:0]     div_next;
    logic [2*DATA_WIDTH-1:0]     prod;
    logic [DATA_WIDTH-1:0]       quo, rem;
    logic [DATA_WIDTH-1:0]       fin_hi, fin_lo;

    assign go           = ex_valid & ~ex_stall & ~flush;
    assign is_mul_op    = (funct == F_MULT) || (funct == F_MULTU);
    assign is_div_op    = (funct == F_DIV)  || (funct == F_DIVU);
    assign is_signed_op = (funct == F_MULT) || (funct == F_DIV);
    assign sign_a       = is_signed_op & op_a[DATA_WIDTH-1];
    assign sign_b       = is_signed_op & op_b[DATA_WIDTH-1];
    assign abs_a        = sign_a ? -op_a : op_a;
    assign abs_b        = sign_b ? -op_b : op_b;

    // Multiply: {HI,LO} starts as {0, multiplier}; add multiplicand into the top half, shift right.
    assign mul_sum  = {1'b0, w_q[2*DATA_WIDTH-1:DATA_WIDTH]} + (w_q[0] ? {1'b0, m_q} : '0);
    assign mul_next = {mul_sum, w_q[DATA_WIDTH-1:1]};

    // Restoring divide: {rem, dividend} shifts left; quotient bits enter at the bottom.
    assign div_rs   = {w_q[2*DATA_WIDTH-1:DATA_WIDTH], w_q[DATA_WIDTH-1]};
    assign div_ge   = div_rs >= {1'b0, m_q};
    assign div_diff = div_rs[DATA_WIDTH-1:0] - m_q;
    assign div_rem  = div_ge ? div_diff : div_rs[DATA_WIDTH-1:0];
    assign div_next = {div_rem, w_q[DATA_WIDTH-2:0], div_ge};

    // A zero divisor yields an all-ones quotient and rem = |dividend|, so the plain
    // sign fix (quotient sign suppressed) gives LO = all ones and HI = op_a.
    assign prod   = neg_lo_q ? -w_q : w_q;
    assign quo    = w_q[DATA_WIDTH-1:0];
    assign rem    = w_q[2*DATA_WIDTH-1:DATA_WIDTH];
    assign fin_hi = is_div_q ? (neg_hi_q ? -rem : rem) : prod[2*DATA_WIDTH-1:DATA_WIDTH];
    assign fin_lo = is_div_q ? (neg_lo_q ? -quo : quo) : prod[DATA_WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            w_q      <= '0;
            m_q      <= '0;
            is_div_q <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            w_q      <= w_d;
            m_q      <= m_d;
            is_div_q <= is_div_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
            busy_q   <= busy_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        w_d       = w_q;
        m_d       = m_q;
        is_div_d  = is_div_q;
        neg_lo_d  = neg_lo_q;
        neg_hi_d  = neg_hi_q;
        stall_req = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (go && (is_mul_op || is_div_op)) begin
                    w_d       = {{DATA_WIDTH{1'b0}}, (is_div_op ? abs_a : abs_b)};
                    m_d       = is_div_op ? abs_b : abs_a;
                    is_div_d  = is_div_op;
                    neg_lo_d  = (sign_a ^ sign_b) & ~(is_div_op && (op_b == '0));
                    neg_hi_d  = sign_a;
                    cnt_d     = CNT_W'(DATA_WIDTH - 1);
                    state_d   = S_ITER;
                    stall_req = 1'b1;
                end else if (go && (funct == F_MTHI)) begin
                    hi_d = op_a;
                end else if (go && (funct == F_MTLO)) begin
                    lo_d = op_a;
                end
            end
            S_ITER: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    stall_req = 1'b1;
                    w_d       = is_div_q ? div_next : mul_next;
                    if (cnt_q == '0) begin
                        state_d = S_FIN;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end
            S_FIN: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    hi_d = fin_hi;
                    lo_d = fin_lo;
                    if (!ex_stall) begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (rst) begin
            stall_req = 1'b0;
        end
    end

    assign busy_d = (state_d != S_IDLE);

    always_comb begin
        result = '0;
        if (funct == F_MFHI) begin
            result = hi_q;
        end else if (funct == F_MFLO) begin
            result = lo_q;
        end
    end

    assign busy   = busy_q;
    assign hi_out = hi_q;
    assign lo_out = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vectors plus random ops
// checked against an arithmetic HI/LO reference model.
module tb_muldiv_unit;

    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;

    logic        clk = 1'b0;
    logic        rst, ex_valid, ex_stall, flush;
    logic [5:0]  funct;
    logic [31:0] op_a, op_b;
    logic        stall_req, busy;
    logic [31:0] hi_out, lo_out, result;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    always #5 clk = ~clk;

    muldiv_unit #(.DATA_WIDTH(32), .FUNCT_WIDTH(6)) dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_stall(ex_stall), .flush(flush),
        .funct(funct), .op_a(op_a), .op_b(op_b), .stall_req(stall_req), .busy(busy),
        .hi_out(hi_out), .lo_out(lo_out), .result(result)
    );

    // Reference: architectural HI/LO effect of one instruction, in plain arithmetic.
    function automatic void model_apply(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        int sa, sb;
        longint sp, q, r;
        longint unsigned up;
        sa = a;
        sb = b;
        case (f)
            F_MULT:  begin sp = longint'(sa) * longint'(sb); m_hi = sp[63:32]; m_lo = sp[31:0]; end
            F_MULTU: begin up = {32'd0, a}; up = up * {32'd0, b}; m_hi = up[63:32]; m_lo = up[31:0]; end
            F_DIV: begin
                if (b == 0) begin m_lo = '1; m_hi = a; end
                else begin
                    q = longint'(sa) / longint'(sb);
                    r = longint'(sa) % longint'(sb);
                    m_lo = q[31:0];
                    m_hi = r[31:0];
                end
            end
            F_DIVU: begin
                if (b == 0) begin m_lo = '1; m_hi = a; end
                else begin m_lo = a / b; m_hi = a % b; end
            end
            F_MTHI: m_hi = a;
            F_MTLO: m_lo = a;
            default: ;
        endcase
    endfunction

    function automatic int exp_stall(input logic [5:0] f);
        return (f == F_MULT || f == F_MULTU || f == F_DIV || f == F_DIVU) ? 33 : 0;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 20));
            4:       return -32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    // Drives one instruction at negedge+1 and returns once it has left EX; cnt = stall_req-high cycles.
    task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b, output int cnt);
        ex_valid = 1'b1; funct = f; op_a = a; op_b = b;
        #1;
        cnt = 0;
        while (stall_req === 1'b1 && cnt < 100) begin
            cnt++;
            @(negedge clk); #1;
        end
        @(negedge clk);
        ex_valid = 1'b0; funct = 6'h00;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; ex_valid = 1'b1; ex_stall = 1'b0; flush = 1'b0;
        funct = F_MULT; op_a = 32'd9; op_b = 32'd9;
        repeat (3) @(negedge clk);
        ex_valid = 1'b0; funct = 6'h00;
        rst = 1'b0;
        #1;
        n_cmp++; if (hi_out !== 32'h0) begin n_err++; $display("FAIL reset_hi got=%h exp=%h", hi_out, 32'h0); end
        n_cmp++; if (lo_out !== 32'h0) begin n_err++; $display("FAIL reset_lo got=%h exp=%h", lo_out, 32'h0); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_cmp++; if (stall_req !== 1'b0) begin n_err++; $display("FAIL reset_stall got=%b exp=0", stall_req); end
        n_cmp++; if (result !== 32'h0) begin n_err++; $display("FAIL reset_result got=%h exp=%h", result, 32'h0); end
    endtask

    task automatic test_spec_vectors();
        logic [5:0]  vf [5] = '{F_MULT, F_MULTU, F_DIV, F_DIVU, F_DIV};
        logic [31:0] va [5] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'd7, 32'h8000_0000};
        logic [31:0] vb [5] = '{32'd5, 32'd2, 32'd2, 32'd0, 32'hFFFF_FFFF};
        logic [31:0] vh [5] = '{32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0007, 32'h0};
        logic [31:0] vl [5] = '{32'hFFFF_FFF1, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h8000_0000};
        int cnt;
        for (int i = 0; i < 5; i++) begin
            issue(vf[i], va[i], vb[i], cnt);
            model_apply(vf[i], va[i], vb[i]);
            n_cmp++; if (cnt !== 33) begin n_err++; $display("FAIL vec%0d_stall_cycles got=%0d exp=33", i, cnt); end
            n_cmp++; if (hi_out !== vh[i]) begin n_err++; $display("FAIL vec%0d_hi got=%h exp=%h", i, hi_out, vh[i]); end
            n_cmp++; if (lo_out !== vl[i]) begin n_err++; $display("FAIL vec%0d_lo got=%h exp=%h", i, lo_out, vl[i]); end
            n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL vec%0d_busy got=%b exp=0", i, busy); end
        end
    endtask

    task automatic test_mthi_mfhi();
        int cnt;
        issue(F_MTHI, 32'h0000_1234, 32'h0, cnt);
        model_apply(F_MTHI, 32'h0000_1234, 32'h0);
        n_cmp++; if (cnt !== 0) begin n_err++; $display("FAIL mthi_stall got=%0d exp=0", cnt); end
        ex_valid = 1'b1; funct = F_MFHI; #1;
        n_cmp++; if (result !== 32'h0000_1234) begin n_err++; $display("FAIL mfhi_result got=%h exp=%h", result, 32'h0000_1234); end
        n_cmp++; if (stall_req !== 1'b0) begin n_err++; $display("FAIL mfhi_stall got=%b exp=0", stall_req); end
        ex_valid = 1'b0; funct = 6'h00;
        @(negedge clk); #1;
        issue(F_MTLO, 32'hCAFE_F00D, 32'h0, cnt);
        model_apply(F_MTLO, 32'hCAFE_F00D, 32'h0);
        ex_valid = 1'b1; funct = F_MFLO; #1;
        n_cmp++; if (result !== m_lo) begin n_err++; $display("FAIL mflo_result got=%h exp=%h", result, m_lo); end
        funct = 6'h20; #1;
        n_cmp++; if (result !== 32'h0) begin n_err++; $display("FAIL other_funct_result got=%h exp=%h", result, 32'h0); end
        ex_valid = 1'b0; funct = 6'h00;
        @(negedge clk); #1;
        n_cmp++; if (hi_out !== m_hi) begin n_err++; $display("FAIL other_funct_hi got=%h exp=%h", hi_out, m_hi); end
    endtask

    task automatic test_idle_gating();
        ex_valid = 1'b0; funct = F_MULT; op_a = 32'd3; op_b = 32'd4; #1;
        n_cmp++; if (stall_req !== 1'b0) begin n_err++; $display("FAIL novalid_stall got=%b exp=0", stall_req); end
        @(negedge clk); #1;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL novalid_busy got=%b exp=0", busy); end
        ex_valid = 1'b1; ex_stall = 1'b1; #1;
        n_cmp++; if (stall_req !== 1'b0) begin n_err++; $display("FAIL exstall_idle_stall got=%b exp=0", stall_req); end
        funct = F_MTHI; op_a = 32'hDEAD_BEEF;
        @(negedge clk); #1;
        n_cmp++; if (hi_out !== m_hi) begin n_err++; $display("FAIL exstall_mthi_hi got=%h exp=%h", hi_out, m_hi); end
        ex_stall = 1'b0; flush = 1'b1; funct = F_MTLO;
        @(negedge clk); #1;
        n_cmp++; if (lo_out !== m_lo) begin n_err++; $display("FAIL flush_mtlo_lo got=%h exp=%h", lo_out, m_lo); end
        funct = F_DIV; #1;
        @(negedge clk); #1;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL flush_idle_busy got=%b exp=0", busy); end
        flush = 1'b0; ex_valid = 1'b0; funct = 6'h00; #1;
    endtask

    task automatic test_random();
        logic [5:0]  ops [6] = '{F_MULT, F_MULTU, F_DIV, F_DIVU, F_MTHI, F_MTLO};
        logic [5:0]  f;
        logic [31:0] a, b;
        int cnt;
        for (int i = 0; i < 24; i++) begin
            f = ops[$urandom_range(0, 5)];
            a = pick();
            b = pick();
            model_apply(f, a, b);
            issue(f, a, b, cnt);
            n_cmp++; if (cnt !== exp_stall(f)) begin n_err++; $display("FAIL rnd%0d_stall f=%h got=%0d exp=%0d", i, f, cnt, exp_stall(f)); end
            n_cmp++; if (hi_out !== m_hi) begin n_err++; $display("FAIL rnd%0d_hi f=%h a=%h b=%h got=%h exp=%h", i, f, a, b, hi_out, m_hi); end
            n_cmp++; if (lo_out !== m_lo) begin n_err++; $display("FAIL rnd%0d_lo f=%h a=%h b=%h got=%h exp=%h", i, f, a, b, lo_out, m_lo); end
            ex_valid = 1'b1; funct = F_MFHI; #1;
            n_cmp++; if (result !== m_hi) begin n_err++; $display("FAIL rnd%0d_mfhi got=%h exp=%h", i, result, m_hi); end
            funct = F_MFLO; #1;
            n_cmp++; if (result !== m_lo) begin n_err++; $display("FAIL rnd%0d_mflo got=%h exp=%h", i, result, m_lo); end
            ex_valid = 1'b0; funct = 6'h00;
            @(negedge clk); #1;
        end
    endtask

    task automatic test_flush();
        ex_valid = 1'b1; funct = F_DIV; op_a = 32'd1000; op_b = 32'd7; #1;
        repeat (10) @(negedge clk);
        #1;
        n_cmp++; if (stall_req !== 1'b1) begin n_err++; $display("FAIL flush_pre_stall got=%b exp=1", stall_req); end
        flush = 1'b1; #1;
        n_cmp++; if (stall_req !== 1'b0) begin n_err++; $display("FAIL flush_stall got=%b exp=0", stall_req); end
        @(negedge clk);
        flush = 1'b0; ex_valid = 1'b0; funct = 6'h00; #1;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL flush_busy got=%b exp=0", busy); end
        repeat (40) @(negedge clk);
        #1;
        n_cmp++; if (hi_out !== m_hi) begin n_err++; $display("FAIL flush_hi got=%h exp=%h", hi_out, m_hi); end
        n_cmp++; if (lo_out !== m_lo) begin n_err++; $display("FAIL flush_lo got=%h exp=%h", lo_out, m_lo); end
    endtask

    task automatic test_fin_stall();
        logic [31:0] a, b;
        int cnt;
        a = $urandom; b = $urandom;
        model_apply(F_MULT, a, b);
        ex_valid = 1'b1; funct = F_MULT; op_a = a; op_b = b; #1;
        cnt = 0;
        while (stall_req === 1'b1 && cnt < 100) begin cnt++; @(negedge clk); #1; end
        n_cmp++; if (cnt !== 33) begin n_err++; $display("FAIL finstall_cycles got=%0d exp=33", cnt); end
        ex_stall = 1'b1; #1;
        for (int k = 0; k < 3; k++) begin
            n_cmp++; if (busy !== 1'b1 || stall_req !== 1'b0) begin n_err++; $display("FAIL finstall%0d busy=%b stall=%b exp busy=1 stall=0", k, busy, stall_req); end
            @(negedge clk); #1;
        end
        ex_stall = 1'b0; #1;
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL finstall_held_busy got=%b exp=1", busy); end
        @(negedge clk);
        ex_valid = 1'b0; funct = 6'h00; #1;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL finstall_release_busy got=%b exp=0", busy); end
        n_cmp++; if (hi_out !== m_hi) begin n_err++; $display("FAIL finstall_hi got=%h exp=%h", hi_out, m_hi); end
        n_cmp++; if (lo_out !== m_lo) begin n_err++; $display("FAIL finstall_lo got=%h exp=%h", lo_out, m_lo); end
    endtask

    task automatic test_back_to_back();
        int c0, c1;
        issue(F_MULTU, 32'h0001_0000, 32'h0003_0000, c0);
        model_apply(F_MULTU, 32'h0001_0000, 32'h0003_0000);
        issue(F_DIV, 32'hFFFF_FF9C, 32'd7, c1);
        model_apply(F_DIV, 32'hFFFF_FF9C, 32'd7);
        n_cmp++; if (c0 !== 33 || c1 !== 33) begin n_err++; $display("FAIL b2b_stall got=%0d,%0d exp=33,33", c0, c1); end
        ex_valid = 1'b1; funct = F_MFLO; #1;
        n_cmp++; if (result !== m_lo) begin n_err++; $display("FAIL b2b_mflo got=%h exp=%h", result, m_lo); end
        funct = F_MFHI; #1;
        n_cmp++; if (result !== m_hi) begin n_err++; $display("FAIL b2b_mfhi got=%h exp=%h", result, m_hi); end
        ex_valid = 1'b0; funct = 6'h00;
        @(negedge clk); #1;
    endtask

    task automatic test_rst_mid();
        int cnt;
        issue(F_MTHI, 32'h0000_AAAA, 32'h0, cnt);
        issue(F_MTLO, 32'h0000_5555, 32'h0, cnt);
        ex_valid = 1'b1; funct = F_MULT; op_a = 32'd12345; op_b = 32'd678; #1;
        repeat (5) @(negedge clk);
        rst = 1'b1; ex_valid = 1'b0; funct = 6'h00;
        @(negedge clk); #1;
        rst = 1'b0;
        m_hi = '0; m_lo = '0;
        n_cmp++; if (hi_out !== 32'h0 || lo_out !== 32'h0) begin n_err++; $display("FAIL rstmid_hilo got=%h/%h exp=0/0", hi_out, lo_out); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
        n_cmp++; if (stall_req !== 1'b0) begin n_err++; $display("FAIL rstmid_stall got=%b exp=0", stall_req); end
        issue(F_DIVU, 32'd100, 32'd7, cnt);
        n_cmp++; if (lo_out !== 32'd14 || hi_out !== 32'd2) begin n_err++; $display("FAIL rstmid_recover got=%h/%h exp=%h/%h", hi_out, lo_out, 32'd2, 32'd14); end
    endtask

    initial begin
        test_reset();
        test_spec_vectors();
        test_mthi_mfhi();
        test_idle_gating();
        test_random();
        test_flush();
        test_fin_stall();
        test_back_to_back();
        test_rst_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
